rsa_job_seq: RTL and testbench

- Wishbone-side sequencer for the memory-mapped RSA accelerator slave. Lets two hardware requesters (e.g. CPU offload port and a DMA/key engine) share one RSA core.
- Accepts job descriptors, arbitrates round-robin, and programs operand registers over the single-cycle-ack bus (M write last, because it triggers start).
- Polls the done status, reads back C, and returns a tagged result. Sits between requesters and the RSA slave, in place of direct CPU loads/stores.

---
 rtl/rsa_pkg.sv | 39 +++
 rtl/rsa_wb_master.sv | 70 +++++++
 rtl/rsa_job_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rsa_job_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants for the RSA job sequencer.
//   - Register byte offsets of the memory-mapped RSA slave.
//   - Sequencer state encodings (plain constants for legacy tools).
//   - NREQ: number of hardware requesters sharing the core.
//   - key_offset(): register offset of the n-th key word (E, N, N_INV, R2).
package rsa_pkg;

  localparam int NREQ = 2;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_M    = 8'h08;
  localparam logic [7:0] OFF_E    = 8'h0C;
  localparam logic [7:0] OFF_N    = 8'h10;
  localparam logic [7:0] OFF_NINV = 8'h14;
  localparam logic [7:0] OFF_R2   = 8'h18;
  localparam logic [7:0] OFF_C    = 8'h1C;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_KEY  = 3'd1;
  localparam state_t ST_WR_M = 3'd2;
  localparam state_t ST_GAP  = 3'd3;
  localparam state_t ST_POLL = 3'd4;
  localparam state_t ST_RD_C = 3'd5;
  localparam state_t ST_RESP = 3'd6;

  // Key words are written in the order E, N, N_INV, R2.
  function automatic logic [7:0] key_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    return OFF_E;
      2'd1:    return OFF_N;
      2'd2:    return OFF_NINV;
      default: return OFF_R2;
    endcase
  endfunction

endpackage

// File: rtl/rsa_wb_master.sv
// rsa_wb_master: single-transaction bus engine towards the RSA slave.
//   clk, rst         clock, asynchronous active-low reset
//   go               start one transaction (ignored while busy)
//   addr/wdata/we    transaction request, sampled with go
//   busy             transaction in flight (strobe asserted)
//   done_pulse       one-cycle pulse the cycle after the ack
//   rdata            read data captured on the ack cycle
//   wb_adr_o/wb_dat_o/wb_we_o/rsa_en_o  registered bus outputs
//   wb_dat_i/wb_ack_i                   slave read data and ack
module rsa_wb_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        busy,
  output logic        done_pulse,
  output logic [31:0] rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        rsa_en_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic        we_reg;
  logic        en_reg;
  logic        done_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_reg   <= 32'h0;
      dat_reg   <= 32'h0;
      we_reg    <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      done_reg <= 1'b0;
      if (en_reg) begin
        // Strobe drops at the edge that sees the ack; the ack is only
        // honoured while our own strobe is up.
        if (wb_ack_i) begin
          en_reg    <= 1'b0;
          rdata_reg <= wb_dat_i;
          done_reg  <= 1'b1;
        end
      end else if (go) begin
        adr_reg <= addr;
        dat_reg <= wdata;
        we_reg  <= we;
        en_reg  <= 1'b1;
      end
    end
  end

  assign busy       = en_reg;
  assign done_pulse = done_reg;
  assign rdata      = rdata_reg;
  assign wb_adr_o   = adr_reg;
  assign wb_dat_o   = dat_reg;
  assign wb_we_o    = we_reg;
  assign rsa_en_o   = en_reg;

endmodule

// File: rtl/rsa_job_seq.sv
// rsa_job_seq: shares one memory-mapped RSA core between two requesters.
//   clk, rst        clock, asynchronous active-low reset
//   req_*           per-requester job offer (operands packed per requester)
//   req_ready       one-hot grant, only while idle
//   rsp_*           tagged result (valid/ready handshake), err on timeout
//   wb_*/rsa_en_o   bus towards the RSA slave
// A job: optional key load (E, N, N_INV, R2), M write (starts the core),
// gap/poll loop on the status register, read of C, response.
module rsa_job_seq
  import rsa_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          POLL_GAP      = 4,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_m,
  input  logic [NREQ*WIDTH-1:0] req_e,
  input  logic [NREQ*WIDTH-1:0] req_n,
  input  logic [NREQ*WIDTH-1:0] req_ninv,
  input  logic [NREQ*WIDTH-1:0] req_r2,
  input  logic [NREQ-1:0]       req_reload,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_c,
  output logic                  rsp_err,
  output logic [31:0]           wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic                  rsa_en_o,
  input  logic                  wb_ack_i
);

  localparam int PCW = $clog2(TIMEOUT_POLLS + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  logic [WIDTH-1:0] m_arr    [NREQ];
  logic [WIDTH-1:0] e_arr    [NREQ];
  logic [WIDTH-1:0] n_arr    [NREQ];
  logic [WIDTH-1:0] ninv_arr [NREQ];
  logic [WIDTH-1:0] r2_arr   [NREQ];

  state_t           state_reg;
  logic             rr_ptr_reg;
  logic             key_owner_reg;
  logic             key_owner_valid_reg;
  logic             job_id_reg;
  logic             job_reload_reg;
  logic [WIDTH-1:0] job_m_reg, job_e_reg, job_n_reg, job_ninv_reg, job_r2_reg;
  logic [1:0]       key_idx_reg;
  logic             issued_reg;
  logic [GCW-1:0]   gap_cnt_reg;
  logic [PCW-1:0]   poll_cnt_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_c_reg;
  logic             rsp_err_reg;

  logic             any_req;
  logic             grant_id;
  logic             key_needed;
  logic             bus_state;
  logic [7:0]       bus_off;
  logic [31:0]      bus_wdata;
  logic             bus_we;
  logic             go;
  logic             mst_busy;
  logic             mst_done;
  logic [31:0]      mst_rdata;
  logic             bus_done;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign m_arr[gi]    = req_m[gi*WIDTH +: WIDTH];
      assign e_arr[gi]    = req_e[gi*WIDTH +: WIDTH];
      assign n_arr[gi]    = req_n[gi*WIDTH +: WIDTH];
      assign ninv_arr[gi] = req_ninv[gi*WIDTH +: WIDTH];
      assign r2_arr[gi]   = req_r2[gi*WIDTH +: WIDTH];
      // Gated by rst so the handshake reads 0 while reset is held.
      assign req_ready[gi] = rst && (state_reg == ST_IDLE) && any_req &&
                             (grant_id == 1'(gi));
    end
  endgenerate

  assign any_req  = |req_valid;
  assign grant_id = req_valid[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

  // The loaded key belongs to this job only if its owner loaded it and no
  // timeout has invalidated it since.
  assign key_needed = job_reload_reg || !key_owner_valid_reg ||
                      (key_owner_reg != job_id_reg);

  always_comb begin
    bus_state = 1'b0;
    bus_off   = OFF_M;
    bus_wdata = job_m_reg;
    bus_we    = 1'b0;
    case (state_reg)
      ST_KEY: begin
        bus_state = key_needed;
        bus_off   = key_offset(key_idx_reg);
        bus_we    = 1'b1;
        case (key_idx_reg)
          2'd0:    bus_wdata = job_e_reg;
          2'd1:    bus_wdata = job_n_reg;
          2'd2:    bus_wdata = job_ninv_reg;
          default: bus_wdata = job_r2_reg;
        endcase
      end
      ST_WR_M: begin
        bus_state = 1'b1;
        bus_we    = 1'b1;
      end
      ST_POLL: begin
        bus_state = 1'b1;
        bus_off   = OFF_STAT;
      end
      ST_RD_C: begin
        bus_state = 1'b1;
        bus_off   = OFF_C;
      end
      default: ;
    endcase
  end

  // One go per bus state visit; issued_reg clears when that transaction
  // completes, so the next bus state issues one cycle later (idle gap).
  assign go       = bus_state && !issued_reg && !mst_busy;
  assign bus_done = mst_done && issued_reg;

  rsa_wb_master u_mst (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .addr      (BASE_ADDR + {24'h0, bus_off}),
    .wdata     (bus_wdata),
    .we        (bus_we),
    .busy      (mst_busy),
    .done_pulse(mst_done),
    .rdata     (mst_rdata),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o),
    .rsa_en_o  (rsa_en_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg           <= ST_IDLE;
      rr_ptr_reg          <= 1'b0;
      key_owner_reg       <= 1'b0;
      key_owner_valid_reg <= 1'b0;
      job_id_reg          <= 1'b0;
      job_reload_reg      <= 1'b0;
      job_m_reg           <= '0;
      job_e_reg           <= '0;
      job_n_reg           <= '0;
      job_ninv_reg        <= '0;
      job_r2_reg          <= '0;
      key_idx_reg         <= 2'd0;
      issued_reg          <= 1'b0;
      gap_cnt_reg         <= '0;
      poll_cnt_reg        <= '0;
      rsp_id_reg          <= 1'b0;
      rsp_c_reg           <= '0;
      rsp_err_reg         <= 1'b0;
    end else begin
      if (go) issued_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            job_id_reg     <= grant_id;
            job_reload_reg <= req_reload[grant_id];
            job_m_reg      <= m_arr[grant_id];
            job_e_reg      <= e_arr[grant_id];
            job_n_reg      <= n_arr[grant_id];
            job_ninv_reg   <= ninv_arr[grant_id];
            job_r2_reg     <= r2_arr[grant_id];
            rr_ptr_reg     <= ~grant_id;
            poll_cnt_reg   <= '0;
            key_idx_reg    <= 2'd0;
            issued_reg     <= 1'b0;
            state_reg      <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (!key_needed) begin
            state_reg <= ST_WR_M;
          end else if (bus_done) begin
            issued_reg <= 1'b0;
            if (key_idx_reg == 2'd3) begin
              key_owner_reg       <= job_id_reg;
              key_owner_valid_reg <= 1'b1;
              key_idx_reg         <= 2'd0;
              state_reg           <= ST_WR_M;
            end else begin
              key_idx_reg <= key_idx_reg + 2'd1;
            end
          end
        end
        ST_WR_M: begin
          if (bus_done) begin
            issued_reg  <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Waiting here also lets a stale done from the previous job clear.
          if (gap_cnt_reg == GCW'(POLL_GAP - 1)) state_reg <= ST_POLL;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        ST_POLL: begin
          if (bus_done) begin
            issued_reg <= 1'b0;
            if (mst_rdata[0]) begin
              state_reg <= ST_RD_C;
            end else if (poll_cnt_reg == PCW'(TIMEOUT_POLLS - 1)) begin
              // Core state is unknown after an abort: force a key reload.
              rsp_id_reg          <= job_id_reg;
              rsp_c_reg           <= '0;
              rsp_err_reg         <= 1'b1;
              key_owner_valid_reg <= 1'b0;
              state_reg           <= ST_RESP;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + 1'b1;
              gap_cnt_reg  <= '0;
              state_reg    <= ST_GAP;
            end
          end
        end
        ST_RD_C: begin
          if (bus_done) begin
            issued_reg  <= 1'b0;
            rsp_id_reg  <= job_id_reg;
            rsp_c_reg   <= mst_rdata;
            rsp_err_reg <= 1'b0;
            state_reg   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_c     = rsp_c_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_rsa_job_seq.sv
// tb_rsa_job_seq: directed bench for rsa_job_seq with a behavioural RSA
// slave (single-cycle ack, done 50 cycles after the M write, C = M^E mod N).
module tb_rsa_job_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, req_reload;
  logic [63:0] req_m, req_e, req_n, req_ninv, req_r2;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_c;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, rsa_en_o, wb_ack_i;

  int total = 0;
  int bad   = 0;

  rsa_job_seq #(
    .WIDTH(32), .BASE_ADDR(BASE), .POLL_GAP(8), .TIMEOUT_POLLS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_e(req_e), .req_n(req_n),
    .req_ninv(req_ninv), .req_r2(req_r2), .req_reload(req_reload),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .rsa_en_o(rsa_en_o), .wb_ack_i(wb_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave model ----------------
  logic        ack_q = 1'b0;
  logic        s_done = 1'b0;
  logic [31:0] s_e = 0, s_n = 0, s_m = 0, s_c = 0;
  int          busy_cnt = 0;
  int          stat_reads = 0;
  bit          never_done = 1'b0;
  int          wr_log[$];
  logic [31:0] off;

  assign off      = wb_adr_o - BASE;
  assign wb_ack_i = ack_q;
  assign wb_dat_i = (off == 32'h04) ? {31'h0, s_done} :
                    (off == 32'h1C) ? s_c : 32'h0;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    longint unsigned r, x, nn;
    if (n == 0) return 32'h0;
    nn = {32'h0, n};
    r  = 1;
    x  = {32'h0, b} % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    ack_q <= rsa_en_o && !ack_q;
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1 && !never_done) begin
        s_done <= 1'b1;
        s_c    <= modexp(s_m, s_e, s_n);
      end
    end
    if (rsa_en_o && ack_q) begin
      if (wb_we_o) begin
        wr_log.push_back(int'(off));
        case (off)
          32'h0C: s_e <= wb_dat_o;
          32'h10: s_n <= wb_dat_o;
          32'h08: begin
            s_m      <= wb_dat_o;
            busy_cnt <= 50;
            s_done   <= 1'b0;
          end
          default: ;
        endcase
      end else if (off == 32'h04) begin
        stat_reads <= stat_reads + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input int id, input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] n, input bit reload);
    req_m[id*32 +: 32]    = m;
    req_e[id*32 +: 32]    = e;
    req_n[id*32 +: 32]    = n;
    req_ninv[id*32 +: 32] = 32'h1111_0000 + id;
    req_r2[id*32 +: 32]   = 32'h2222_0000 + id;
    req_reload[id]        = reload;
  endtask

  task automatic wait_ready(input logic [1:0] exp, input int budget);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 64'(req_ready), 64'(exp));
  endtask

  task automatic offer(input int id, input logic [31:0] m, input logic [31:0] e,
                       input logic [31:0] n, input bit reload);
    @(posedge clk); #1;
    drive_ops(id, m, e, n, reload);
    req_valid[id] = 1'b1;
    wait_ready(2'(1 << id), 200);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    $display("grant id=%0d m=%0d reload=%0d", id, m, reload);
  endtask

  task automatic get_rsp(input int exp_id, input logic [31:0] exp_c, input bit exp_err);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(exp_id));
    check("rsp_c", 64'(rsp_c), 64'(exp_c));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    $display("rsp id=%0d c=%0d err=%0d", rsp_id, rsp_c, rsp_err);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_writes(input int base, input bit exp_key);
    int exp_list[5];
    int n_exp;
    if (exp_key) begin
      exp_list = '{12, 16, 20, 24, 8};
      n_exp    = 5;
    end else begin
      exp_list[0] = 8;
      n_exp       = 1;
    end
    check("write_count", 64'(wr_log.size() - base), 64'(n_exp));
    for (int i = 0; i < n_exp; i++)
      if (base + i < wr_log.size())
        check("write_addr", 64'(wr_log[base + i]), 64'(exp_list[i]));
  endtask

  typedef struct {
    int          id;
    logic [31:0] m, e, n;
    bit          reload;
    bit          never;
    bit          exp_key;
    logic [31:0] exp_c;
    bit          exp_err;
    int          exp_polls;
  } vec_t;

  task automatic run_job(input vec_t v);
    int wb_base = wr_log.size();
    int st_base = stat_reads;
    never_done = v.never;
    offer(v.id, v.m, v.e, v.n, v.reload);
    get_rsp(v.id, v.exp_c, v.exp_err);
    check_writes(wb_base, v.exp_key);
    if (v.exp_polls > 0)
      check("status_reads", 64'(stat_reads - st_base), 64'(v.exp_polls));
    never_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[8];
    int   wb_base;
    int   n;
    bit   found;

    //         id  m    e   n     rl nd key c     err polls
    vecs[0] = '{0, 65,  17, 3233, 1, 0, 1, 2790, 0, 0};
    vecs[1] = '{0, 123, 17, 3233, 0, 0, 0, 855,  0, 0};
    vecs[2] = '{1, 9,   7,  143,  1, 0, 1, 48,   0, 0};
    vecs[3] = '{1, 9,   7,  143,  0, 1, 0, 0,    1, 8};  // timeout
    vecs[4] = '{1, 9,   7,  143,  0, 0, 1, 48,   0, 0};  // key lost by timeout
    vecs[5] = '{0, 123, 17, 3233, 0, 0, 1, 855,  0, 0};  // owner was req1
    vecs[6] = '{1, 9,   7,  143,  0, 0, 1, 48,   0, 0};  // leaves rr_ptr = 0
    vecs[7] = '{0, 65,  17, 3233, 0, 0, 1, 2790, 0, 0};  // after mid-job reset

    rst        = 1'b1;
    req_valid  = 2'b01;
    req_reload = 2'b00;
    req_m = '0; req_e = '0; req_n = '0; req_ninv = '0; req_r2 = '0;
    rsp_ready  = 1'b0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_c", 64'(rsp_c), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    check("rst_we", 64'(wb_we_o), 64'd0);
    check("rst_en", 64'(rsa_en_o), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Both requesters at once with rr_ptr = 0: req0 first, then req1,
    // whose key is rewritten although reload = 0.
    @(posedge clk); #1;
    wb_base = wr_log.size();
    drive_ops(0, 65, 17, 3233, 0);
    drive_ops(1, 9, 7, 143, 0);
    req_valid = 2'b11;
    wait_ready(2'b01, 200);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    get_rsp(0, 2790, 0);
    check_writes(wb_base, 1);
    wb_base = wr_log.size();
    wait_ready(2'b10, 200);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    get_rsp(1, 48, 0);
    check_writes(wb_base, 1);

    // Response back-pressure with req1 waiting.
    wb_base = wr_log.size();
    offer(0, 123, 17, 3233, 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
    check_writes(wb_base, 1);
    wb_base = wr_log.size();
    drive_ops(1, 9, 7, 143, 0);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold", {26'h0, rsp_valid, rsp_id, rsp_err, req_ready, rsa_en_o, rsp_c},
            {26'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd855});
    end
    $display("rsp id=%0d c=%0d err=%0d (held)", rsp_id, rsp_c, rsp_err);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("grant_after_accept", 64'(req_ready), 64'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    get_rsp(1, 48, 0);
    check_writes(wb_base, 1);

    // Reset while the N write is on the bus.
    offer(0, 65, 17, 3233, 1);
    n = 0;
    found = 1'b0;
    while (!found && n < 500) begin
      @(negedge clk);
      found = rsa_en_o && (wb_adr_o == BASE + 32'h10);
      n++;
    end
    check("saw_n_write", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_ctl", {58'h0, req_ready, rsp_valid, rsp_id, rsp_err, rsa_en_o, wb_we_o}, 64'd0);
    check("async_rst_adr", 64'(wb_adr_o), 64'd0);
    check("async_rst_dat", 64'(wb_dat_o), 64'd0);
    check("async_rst_c", 64'(rsp_c), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {62'h0, rsa_en_o, rsp_valid}, 64'd0);
    run_job(vecs[7]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
